// File: rtl/wb_queue_pkg.sv
// Shared CPU package: default register widths, queue depth and the
// writeback-entry record used by the writeback queue and register file.
package wb_queue_pkg;

    localparam int WB_DW    = 16;
    localparam int WB_AW    = 4;
    localparam int WB_DEPTH = 4;

    // One pending register-file write: destination register plus data.
    typedef struct packed {
        logic [WB_AW-1:0] dest;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Bus bundle for the writeback queue.
// The load and ALU offer ports, the register-file write port and the two
// decode bypass ports are grouped here.
interface wb_queue_if
    import wb_queue_pkg::*;
#(
    parameter int DW = WB_DW,
    parameter int AW = WB_AW
);

    logic          mem_valid;
    logic [AW-1:0] mem_dest;
    logic [DW-1:0] mem_data;
    logic          mem_ready;

    logic          alu_valid;
    logic [AW-1:0] alu_dest;
    logic [DW-1:0] alu_data;
    logic          alu_ready;

    logic          wb_grant;
    logic          wr_en;
    logic [AW-1:0] wr_dest;
    logic [DW-1:0] wr_data;

    logic [AW-1:0] rd_addr_1;
    logic [AW-1:0] rd_addr_2;
    logic          byp_hit_1;
    logic          byp_hit_2;
    logic [DW-1:0] byp_data_1;
    logic [DW-1:0] byp_data_2;

    // The queue itself: it takes offers and drives writes and bypass.
    modport slave (
        input  mem_valid, mem_dest, mem_data, alu_valid, alu_dest, alu_data,
               wb_grant, rd_addr_1, rd_addr_2,
        output mem_ready, alu_ready, wr_en, wr_dest, wr_data,
               byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
    );

    // The surrounding pipeline: it makes offers and consumes writes and bypass.
    modport master (
        output mem_valid, mem_dest, mem_data, alu_valid, alu_dest, alu_data,
               wb_grant, rd_addr_1, rd_addr_2,
        input  mem_ready, alu_ready, wr_en, wr_dest, wr_data,
               byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
    );

endinterface

// File: rtl/wb_bypass_match.sv
// Youngest-match search for one decode read port.
// The entry vectors are ordered oldest (index 0) to youngest (index DEPTH-1).
// Register 0 never hits.
module wb_bypass_match
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW
) (
    input  logic [AW-1:0]       rd_addr,
    input  logic [DEPTH-1:0]    ent_valid,
    input  logic [DEPTH*AW-1:0] ent_dest,
    input  logic [DEPTH*DW-1:0] ent_data,
    output logic                hit,
    output logic [DW-1:0]       data
);

    // Walk oldest to youngest so that the last match found is the youngest one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (rd_addr != '0) && (ent_dest[i*AW +: AW] == rd_addr)) begin
                hit  = 1'b1;
                data = ent_data[i*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: an in-order FIFO of pending register-file writes.
// Load results take priority over ALU results at the input. The head entry
// drains whenever the write port is granted. Every stored entry is visible
// to the two decode bypass ports.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_queue_if.slave              bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] dest_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic          full;
    logic          empty;
    logic          mem_fire;
    logic          alu_fire;
    logic          enq;
    logic          deq;
    logic [AW-1:0] enq_dest;
    logic [DW-1:0] enq_data;

    logic [DEPTH-1:0]    ord_valid;
    logic [DEPTH*AW-1:0] ord_dest;
    logic [DEPTH*DW-1:0] ord_data;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Readiness depends only on the stored count, never on a same-cycle pop.
    // A pending load shuts out the ALU.
    assign bus.mem_ready = ~full;
    assign bus.alu_ready = ~full & ~bus.mem_valid;

    assign deq       = ~empty & bus.wb_grant;
    assign bus.wr_en = deq;

    // Choose which offer (if any) is taken. Writes to register 0 complete
    // the handshake but are dropped instead of stored.
    always_comb begin
        mem_fire = bus.mem_valid & ~full;
        alu_fire = bus.alu_valid & bus.alu_ready;
        enq_dest = bus.alu_dest;
        enq_data = bus.alu_data;
        if (mem_fire) begin
            enq_dest = bus.mem_dest;
            enq_data = bus.mem_data;
        end
        enq = (mem_fire | alu_fire) & (enq_dest != '0);
    end

    // Present the head entry to the register file, or zeros when nothing is pending.
    always_comb begin
        bus.wr_dest = '0;
        bus.wr_data = '0;
        if (!empty) begin
            bus.wr_dest = dest_mem[head];
            bus.wr_data = data_mem[head];
        end
    end

    // Pointer and occupancy bookkeeping. Reset drops every pending entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    // Entry storage. It is never reset because the pointers define what is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            dest_mem[tail] <= enq_dest;
            data_mem[tail] <= enq_data;
        end
    end

    // Lay the live entries out oldest-first so each bypass search can favour the youngest.
    always_comb begin
        ord_valid = '0;
        ord_dest  = '0;
        ord_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ord_valid[i]         = (CW'(i) < count);
            ord_dest[i*AW +: AW] = dest_mem[head + PW'(i)];
            ord_data[i*DW +: DW] = data_mem[head + PW'(i)];
        end
    end

    wb_bypass_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_match_1 (
        .rd_addr   (bus.rd_addr_1),
        .ent_valid (ord_valid),
        .ent_dest  (ord_dest),
        .ent_data  (ord_data),
        .hit       (bus.byp_hit_1),
        .data      (bus.byp_data_1)
    );

    wb_bypass_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_match_2 (
        .rd_addr   (bus.rd_addr_2),
        .ent_valid (ord_valid),
        .ent_dest  (ord_dest),
        .ent_data  (ord_data),
        .hit       (bus.byp_hit_2),
        .data      (bus.byp_data_2)
    );

endmodule
